// File: rtl/mult3_req_seq_if.sv
// Handshake and bus bundle between the request sequencer, its upstream
// producer, the multiplier controller/datapath and the downstream consumer.
// The slave modport is the sequencer's view; master is the surrounding system.
interface mult3_req_seq_if #(
  parameter int WIDTH = 8
);

  // Operand request channel
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;

  // Multiplier controller / datapath side
  logic               mc_start;
  logic               mc_done;
  logic [WIDTH-1:0]   mc_multiplicand;
  logic [WIDTH-1:0]   mc_multiplier;
  logic [2*WIDTH-1:0] dp_product;

  // Result channel
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic               out_err;

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  mc_done,
    input  dp_product,
    input  out_ready,
    output in_ready,
    output mc_start,
    output mc_multiplicand,
    output mc_multiplier,
    output out_valid,
    output out_prod,
    output out_err
  );

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output mc_done,
    output dp_product,
    output out_ready,
    input  in_ready,
    input  mc_start,
    input  mc_multiplicand,
    input  mc_multiplier,
    input  out_valid,
    input  out_prod,
    input  out_err
  );

endinterface

// File: rtl/mult3_req_seq.sv
// Upstream request sequencer for the shift/add multiplier.
// Accepts an operand pair, registers it onto the operand buses, pulses
// mc_start, waits for mc_done (guarded by a watchdog) and returns the
// captured product over a valid/ready result channel.
// Optional feature: define MULT3_SIGNED_EN to treat operands as two's
// complement (magnitudes go to the multiplier, the product is re-signed).
module mult3_req_seq #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 128
) (
  input  logic             clk,
  input  logic             reset,
  mult3_req_seq_if.slave   bus
);

  localparam int CNT_W  = $clog2(TIMEOUT) + 1;
  localparam int PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t              state_q,    state_d;
  logic                in_ready_q, in_ready_d;
  logic [WIDTH-1:0]    mcand_q,    mcand_d;
  logic [WIDTH-1:0]    mplier_q,   mplier_d;
  logic                sign_q,     sign_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [PROD_W-1:0]   prod_q,     prod_d;
  logic                err_q,      err_d;

  logic                accept;
  logic                timeout_hit;
  logic [WIDTH-1:0]    a_mag;
  logic [WIDTH-1:0]    b_mag;
  logic                in_sign;
  logic [PROD_W-1:0]   signed_prod;

  // Operand conditioning: magnitudes and product sign in signed mode,
  // straight pass-through with a zero sign otherwise.
`ifdef MULT3_SIGNED_EN
  assign a_mag   = bus.in_a[WIDTH-1] ? (~bus.in_a + WIDTH'(1)) : bus.in_a;
  assign b_mag   = bus.in_b[WIDTH-1] ? (~bus.in_b + WIDTH'(1)) : bus.in_b;
  assign in_sign = bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
`else
  assign a_mag   = bus.in_a;
  assign b_mag   = bus.in_b;
  assign in_sign = 1'b0;
`endif

  // A transfer only happens while the registered ready is high, which is
  // only ever true in IDLE.
  assign accept      = bus.in_valid && in_ready_q;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign signed_prod = sign_q ? (~bus.dp_product + PROD_W'(1)) : bus.dp_product;

  // Next-state and datapath register updates for the request sequencer.
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    sign_d     = sign_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    err_d      = err_q;
    in_ready_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          sign_d   = in_sign;
          cnt_d    = '0;
          state_d  = S_START;
        end
      end

      S_START: begin
        // The watchdog counts from the start pulse so the abort lands
        // exactly TIMEOUT cycles after mc_start.
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_WAIT;
      end

      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.mc_done) begin
          prod_d  = signed_prod;
          err_d   = 1'b0;
          state_d = S_RESULT;
        end else if (timeout_hit) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESULT;
        end
      end

      S_RESULT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Ready is registered from the next state, so it rises one cycle after
    // reset release or after the result handshake, never combinationally.
    in_ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      sign_q     <= 1'b0;
      cnt_q      <= '0;
      prod_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      sign_q     <= sign_d;
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready        = in_ready_q;
  assign bus.mc_start        = (state_q == S_START);
  assign bus.mc_multiplicand = mcand_q;
  assign bus.mc_multiplier   = mplier_q;
  assign bus.out_valid       = (state_q == S_RESULT);
  assign bus.out_prod        = prod_q;
  assign bus.out_err         = err_q;

endmodule

// File: tb/tb_mult3_req_seq.sv
// Testbench for mult3_req_seq: models the multiplier controller/datapath,
// drives directed operand requests and checks results via a scoreboard.
// Builds with or without MULT3_SIGNED_EN; expectations follow the macro.
module tb_mult3_req_seq;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 128;

  typedef struct packed {
    logic        err;
    logic [15:0] prod;
  } exp_t;

  logic clk;
  logic reset;

  mult3_req_seq_if #(.WIDTH(WIDTH)) bus ();

  mult3_req_seq #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  logic model_done;
  logic spurious_done;
  int   model_delay;
  bit   model_hang;

  assign bus.mc_done = model_done | spurious_done;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] global timeout");
  end

  // Controller/datapath model: on a start pulse, form the product of the
  // operand buses and raise mc_done for one cycle model_delay cycles later.
  initial begin
    model_done     = 1'b0;
    bus.dp_product = '0;
    forever begin
      @(negedge clk);
      if (bus.mc_start === 1'b1) begin
        bus.dp_product = 16'(bus.mc_multiplicand) * 16'(bus.mc_multiplier);
        if (!model_hang) begin
          repeat (model_delay) @(negedge clk);
          model_done = 1'b1;
          @(negedge clk);
          model_done = 1'b0;
        end
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation: request, start pulse, wait for result, optional
  // back-pressure on the result, then handshake.
  task automatic apply_stimulus(input string name,
                                input logic [7:0] a, input logic [7:0] b,
                                input int delay, input bit hang,
                                input logic [7:0] exp_mcand, input logic [7:0] exp_mplier,
                                input logic [15:0] exp_prod, input bit exp_err,
                                input int hold);
    int   n;
    int   exp_lat;
    exp_t e;
    exp_t got;
    model_delay = delay;
    model_hang  = hang;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    e.err  = exp_err;
    e.prod = exp_prod;
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_output({name, "_mc_start"}, 32'(bus.mc_start), 32'd1);
    check_output({name, "_mcand"}, 32'(bus.mc_multiplicand), 32'(exp_mcand));
    check_output({name, "_mplier"}, 32'(bus.mc_multiplier), 32'(exp_mplier));
    check_output({name, "_busy_not_ready"}, 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    n = 1;
    check_output({name, "_start_one_cycle"}, 32'(bus.mc_start), 32'd0);
    while (bus.out_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    exp_lat = hang ? TIMEOUT : delay + 1;
    check_output({name, "_latency"}, 32'(n), 32'(exp_lat));
    if (bus.out_valid === 1'b1) begin
      check_output({name, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        got = sb.pop_front();
        check_output({name, "_prod"}, 32'(bus.out_prod), 32'(got.prod));
        check_output({name, "_err"}, 32'(bus.out_err), 32'(got.err));
      end
      if (hold > 0) begin
        bus.out_ready = 1'b0;
        bus.in_a      = ~a;
        bus.in_b      = ~b;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          check_output({name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
          check_output({name, "_hold_prod"}, 32'(bus.out_prod), 32'(exp_prod));
          check_output({name, "_hold_not_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_output({name, "_valid_drops"}, 32'(bus.out_valid), 32'd0);
      check_output({name, "_ready_back"}, 32'(bus.in_ready), 32'd1);
      check_output({name, "_operands_held"}, 32'(bus.mc_multiplicand), 32'(exp_mcand));
    end
  endtask

  initial begin
    int   seen;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    spurious_done = 1'b0;
    model_delay   = 1;
    model_hang    = 1'b0;
    reset         = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("rst_mc_start", 32'(bus.mc_start), 32'd0);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_out_err", 32'(bus.out_err), 32'd0);
    check_output("rst_out_prod", 32'(bus.out_prod), 32'd0);
    check_output("rst_mcand", 32'(bus.mc_multiplicand), 32'd0);
    check_output("rst_mplier", 32'(bus.mc_multiplier), 32'd0);
    reset = 1'b1;
    #1;
    check_output("rel_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check_output("rel_in_ready_high", 32'(bus.in_ready), 32'd1);

    $display("[TB] basic 7*6");
    apply_stimulus("basic", 8'd7, 8'd6, 24, 1'b0, 8'd7, 8'd6, 16'h002A, 1'b0, 0);

`ifdef MULT3_SIGNED_EN
    $display("[TB] signed build");
    apply_stimulus("neg_a", 8'hFD, 8'd5, 10, 1'b0, 8'd3, 8'd5, 16'hFFF1, 1'b0, 0);
    apply_stimulus("min_min", 8'h80, 8'h80, 1, 1'b0, 8'h80, 8'h80, 16'h4000, 1'b0, 0);
    apply_stimulus("neg_b", 8'd2, 8'hFE, 3, 1'b0, 8'd2, 8'd2, 16'hFFFC, 1'b0, 0);
    apply_stimulus("hold", 8'hFF, 8'hFF, 5, 1'b0, 8'd1, 8'd1, 16'h0001, 1'b0, 10);
`else
    $display("[TB] unsigned build");
    apply_stimulus("neg_a", 8'hFD, 8'd5, 10, 1'b0, 8'hFD, 8'd5, 16'h04F1, 1'b0, 0);
    apply_stimulus("min_min", 8'h80, 8'h80, 1, 1'b0, 8'h80, 8'h80, 16'h4000, 1'b0, 0);
    apply_stimulus("neg_b", 8'd2, 8'hFE, 3, 1'b0, 8'd2, 8'hFE, 16'h01FC, 1'b0, 0);
    apply_stimulus("hold", 8'hFF, 8'hFF, 5, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 10);
`endif

    $display("[TB] watchdog abort");
    apply_stimulus("timeout", 8'd3, 8'd4, 1, 1'b1, 8'd3, 8'd4, 16'h0000, 1'b1, 0);

    $display("[TB] done coincides with watchdog");
    apply_stimulus("done_wins", 8'd5, 8'd9, TIMEOUT - 1, 1'b0, 8'd5, 8'd9, 16'h002D, 1'b0, 0);

    // mc_done while idle must be ignored
    spurious_done = 1'b1;
    repeat (2) @(negedge clk);
    spurious_done = 1'b0;
    check_output("spur_mc_start", 32'(bus.mc_start), 32'd0);
    @(negedge clk);
    check_output("spur_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("spur_in_ready", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of WAIT aborts without a result
    $display("[TB] reset mid-wait");
    model_hang   = 1'b1;
    bus.in_a     = 8'd9;
    bus.in_b     = 8'd9;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_output("mid_mc_start", 32'(bus.mc_start), 32'd1);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_output("mid_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("mid_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("mid_mcand", 32'(bus.mc_multiplicand), 32'd0);
    reset = 1'b1;
    #1;
    check_output("mid_rel_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check_output("mid_rel_ready_high", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < TIMEOUT + 10; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 || bus.mc_start === 1'b1) seen++;
    end
    check_output("mid_no_stale", 32'(seen), 32'd0);
    model_hang = 1'b0;

    // Operation after the abort works normally
    apply_stimulus("after_rst", 8'd12, 8'd11, 7, 1'b0, 8'd12, 8'd11, 16'h0084, 1'b0, 0);

    check_output("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
